// File: rtl/morse_decoder_pkg.sv
// Shared character codes, FSM state encodings and pattern widths for the Morse front end.
// Character codes match the display path: 0-9 -> 0..9, A-Z -> 10..35, NONE -> 63 (blank).
`ifndef MORSE_DEFINES_SVH
`define MORSE_DEFINES_SVH
`define CHAR_W 6
`define CHAR_CODE_0 6'd0
`define CHAR_CODE_1 6'd1
`define CHAR_CODE_2 6'd2
`define CHAR_CODE_3 6'd3
`define CHAR_CODE_4 6'd4
`define CHAR_CODE_5 6'd5
`define CHAR_CODE_6 6'd6
`define CHAR_CODE_7 6'd7
`define CHAR_CODE_8 6'd8
`define CHAR_CODE_9 6'd9
`define CHAR_CODE_A 6'd10
`define CHAR_CODE_B 6'd11
`define CHAR_CODE_C 6'd12
`define CHAR_CODE_D 6'd13
`define CHAR_CODE_E 6'd14
`define CHAR_CODE_F 6'd15
`define CHAR_CODE_G 6'd16
`define CHAR_CODE_H 6'd17
`define CHAR_CODE_I 6'd18
`define CHAR_CODE_J 6'd19
`define CHAR_CODE_K 6'd20
`define CHAR_CODE_L 6'd21
`define CHAR_CODE_M 6'd22
`define CHAR_CODE_N 6'd23
`define CHAR_CODE_O 6'd24
`define CHAR_CODE_P 6'd25
`define CHAR_CODE_Q 6'd26
`define CHAR_CODE_R 6'd27
`define CHAR_CODE_S 6'd28
`define CHAR_CODE_T 6'd29
`define CHAR_CODE_U 6'd30
`define CHAR_CODE_V 6'd31
`define CHAR_CODE_W 6'd32
`define CHAR_CODE_X 6'd33
`define CHAR_CODE_Y 6'd34
`define CHAR_CODE_Z 6'd35
`define CHAR_CODE_NONE 6'd63
`define MORSE_ST_IDLE 2'd0
`define MORSE_ST_MARK 2'd1
`define MORSE_ST_SPACE 2'd2
`define MORSE_ST_EMIT 2'd3
`endif

package morse_decoder_pkg;

  localparam int LEN_W = 3;
  localparam int PAT_W = 5;
  localparam logic [LEN_W-1:0] MAX_LEN = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = `MORSE_ST_IDLE,
    ST_MARK  = `MORSE_ST_MARK,
    ST_SPACE = `MORSE_ST_SPACE,
    ST_EMIT  = `MORSE_ST_EMIT
  } state_e;

endpackage

// File: rtl/morse_decoder_lut.sv
// morse_lut: combinational Morse pattern lookup; the first element is the MSB of the
// len-bit field and 1 means dash. Unmapped len/pattern pairs give hit=0 and CHAR_CODE_NONE.
module morse_lut
  import morse_decoder_pkg::*;
(
  input  logic [LEN_W-1:0]   len,
  input  logic [PAT_W-1:0]   pattern,
  output logic [`CHAR_W-1:0] code,
  output logic               hit
);

  logic [PAT_W-1:0]       mask;
  logic [LEN_W+PAT_W-1:0] key;

  // Bits above len are stale shift history, so they are masked out before matching.
  always_comb begin
    mask = (5'b00001 << len) - 5'd1;
    key  = {len, pattern & mask};
    code = `CHAR_CODE_NONE;
    hit  = 1'b1;
    case (key)
      8'b001_00000: code = `CHAR_CODE_E;
      8'b001_00001: code = `CHAR_CODE_T;
      8'b010_00000: code = `CHAR_CODE_I;
      8'b010_00001: code = `CHAR_CODE_A;
      8'b010_00010: code = `CHAR_CODE_N;
      8'b010_00011: code = `CHAR_CODE_M;
      8'b011_00000: code = `CHAR_CODE_S;
      8'b011_00001: code = `CHAR_CODE_U;
      8'b011_00010: code = `CHAR_CODE_R;
      8'b011_00011: code = `CHAR_CODE_W;
      8'b011_00100: code = `CHAR_CODE_D;
      8'b011_00101: code = `CHAR_CODE_K;
      8'b011_00110: code = `CHAR_CODE_G;
      8'b011_00111: code = `CHAR_CODE_O;
      8'b100_00000: code = `CHAR_CODE_H;
      8'b100_00001: code = `CHAR_CODE_V;
      8'b100_00010: code = `CHAR_CODE_F;
      8'b100_00100: code = `CHAR_CODE_L;
      8'b100_00110: code = `CHAR_CODE_P;
      8'b100_00111: code = `CHAR_CODE_J;
      8'b100_01000: code = `CHAR_CODE_B;
      8'b100_01001: code = `CHAR_CODE_X;
      8'b100_01010: code = `CHAR_CODE_C;
      8'b100_01011: code = `CHAR_CODE_Y;
      8'b100_01100: code = `CHAR_CODE_Z;
      8'b100_01101: code = `CHAR_CODE_Q;
      8'b101_11111: code = `CHAR_CODE_0;
      8'b101_01111: code = `CHAR_CODE_1;
      8'b101_00111: code = `CHAR_CODE_2;
      8'b101_00011: code = `CHAR_CODE_3;
      8'b101_00001: code = `CHAR_CODE_4;
      8'b101_00000: code = `CHAR_CODE_5;
      8'b101_10000: code = `CHAR_CODE_6;
      8'b101_11000: code = `CHAR_CODE_7;
      8'b101_11100: code = `CHAR_CODE_8;
      8'b101_11110: code = `CHAR_CODE_9;
      default:      hit  = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: times a synchronised Morse key in tick_en units, builds dot/dash patterns
// and emits one character per letter gap. Define MORSE_ERR_HOLD_EN to add the err output.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int DASH_MIN_TICKS = 2,
  parameter int GAP_TICKS      = 3,
  parameter int CNT_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               key_in,
  output logic [`CHAR_W-1:0] char,
  output logic               char_valid,
`ifdef MORSE_ERR_HOLD_EN
  output logic               err,
`endif
  output logic               busy
);

  localparam logic [CNT_W-1:0] DASH_MIN = CNT_W'(DASH_MIN_TICKS);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic               key_meta_q, key_s_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [`CHAR_W-1:0] char_q, char_d;
  logic               char_valid_q, char_valid_d;
  logic               err_q, err_d;
  logic [`CHAR_W-1:0] lut_code;
  logic               lut_hit;
  logic               is_dash;

  morse_lut u_lut (
    .len     (len_q),
    .pattern (pattern_q),
    .code    (lut_code),
    .hit     (lut_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q   <= 1'b0;
      key_s_q      <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pattern_q    <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      char_q       <= `CHAR_CODE_NONE;
      char_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      key_meta_q   <= key_in;
      key_s_q      <= key_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pattern_q    <= pattern_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      err_q        <= err_d;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign is_dash = (cnt_q >= DASH_MIN);

  // Key edges are tested before tick_en so a coincident tick is never counted.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pattern_d    = pattern_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    char_d       = char_q;
    char_valid_d = 1'b0;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (key_s_q) begin
          state_d = ST_MARK;
          cnt_d   = '0;
        end
      end
      ST_MARK: begin
        if (!key_s_q) begin
          cnt_d = '0;
          if (cnt_q == '0) begin
            state_d = (len_q == '0) ? ST_IDLE : ST_SPACE;
          end else begin
            state_d = ST_SPACE;
            if (len_q == MAX_LEN) begin
              ovf_d = 1'b1;
            end else begin
              pattern_d = {pattern_q[PAT_W-2:0], is_dash};
              len_d     = len_q + LEN_W'(1);
            end
          end
        end else if (tick_en) begin
          cnt_d = cnt_inc;
        end
      end
      ST_SPACE: begin
        if (key_s_q) begin
          state_d = ST_MARK;
          cnt_d   = '0;
        end else if (tick_en) begin
          cnt_d = cnt_inc;
          if (cnt_q >= GAP_LAST) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        char_valid_d = 1'b1;
`ifdef MORSE_ERR_HOLD_EN
        if (ovf_q || !lut_hit) begin
          err_d = 1'b1;
        end else begin
          err_d  = 1'b0;
          char_d = lut_code;
        end
`else
        char_d = (ovf_q || !lut_hit) ? `CHAR_CODE_NONE : lut_code;
`endif
        pattern_d = '0;
        len_d     = '0;
        ovf_d     = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == ST_MARK) || (state_q == ST_SPACE);
    char       = char_q;
    char_valid = char_valid_q;
  end

`ifdef MORSE_ERR_HOLD_EN
  assign err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
